// File: rtl/axi4_slave_ram_pkg.sv
// Shared AXI4 response/burst codes and FSM state types for the AXI4 slave RAM.
package axi4_slave_ram_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi4_slave_ram_mem.sv
// Simple dual-port RAM: one byte-enable write port, one registered read port.
module axi4_slave_ram_mem #(
    parameter int DW    = 128,
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [IW-1:0]   waddr,
    input  logic [DW/8-1:0] wstrb,
    input  logic [DW-1:0]   wdata,
    input  logic            re,
    input  logic [IW-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < DW/8; i++) begin
                if (wstrb[i]) ram[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    // Output register only reloads when enabled, so a stalled read beat stays stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)  rdata_q <= '0;
        else if (re) rdata_q <= ram[raddr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi4_slave_ram.sv
// AXI4 slave backed by on-chip RAM; independent write and read FSMs, one burst each in flight.
module axi4_slave_ram
    import axi4_slave_ram_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 28,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int MEM_DEPTH      = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]                  s_axi_awlen,
    input  logic [2:0]                  s_axi_awsize,
    input  logic [1:0]                  s_axi_awburst,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                        s_axi_wlast,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_bid,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]     s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]                  s_axi_arlen,
    input  logic [2:0]                  s_axi_arsize,
    input  logic [1:0]                  s_axi_arburst,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rlast,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready
);

    localparam int DW  = AXI_DATA_WIDTH;
    localparam int IDW = AXI_ID_WIDTH;
    localparam int OFF = $clog2(DW/8);
    localparam int IW  = $clog2(MEM_DEPTH);

    wr_state_e          w_state_q, w_state_d;
    logic               awready_q, awready_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [IDW-1:0]     bid_q, bid_d;
    logic [1:0]         bresp_q, bresp_d;
    logic [IW-1:0]      w_idx_q, w_idx_d;
    logic [7:0]         w_cnt_q, w_cnt_d;
    logic [7:0]         w_len_q, w_len_d;
    logic               w_err_q, w_err_d;
    logic               w_last_beat, w_err_next;

    rd_state_e          r_state_q, r_state_d;
    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic [IDW-1:0]     rid_q, rid_d;
    logic [1:0]         rresp_q, rresp_d;
    logic               rlast_q, rlast_d;
    logic [IW-1:0]      r_idx_q, r_idx_d;
    logic [7:0]         r_cnt_q, r_cnt_d;
    logic [7:0]         r_len_q, r_len_d;
    logic               r_err_q, r_err_d;
    logic               ar_err;

    logic               mem_we, mem_re;
    logic [IW-1:0]      mem_raddr;
    logic [DW-1:0]      mem_rdata;

    logic               unused_inputs;
    assign unused_inputs = ^{s_axi_awsize, s_axi_arsize, s_axi_awaddr, s_axi_araddr};

    always_comb begin
        w_state_d   = w_state_q;
        awready_d   = awready_q;
        wready_d    = wready_q;
        bvalid_d    = bvalid_q;
        bid_d       = bid_q;
        bresp_d     = bresp_q;
        w_idx_d     = w_idx_q;
        w_cnt_d     = w_cnt_q;
        w_len_d     = w_len_q;
        w_err_d     = w_err_q;
        w_last_beat = (w_cnt_q == w_len_q);
        w_err_next  = w_err_q | (s_axi_wlast != w_last_beat);
        mem_we      = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (s_axi_awvalid && awready_q) begin
                    bid_d     = s_axi_awid;
                    w_idx_d   = s_axi_awaddr[OFF +: IW];
                    w_len_d   = s_axi_awlen;
                    w_cnt_d   = 8'd0;
                    w_err_d   = (s_axi_awburst != BURST_INCR);
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                // Beat count, not wlast, decides where the burst ends; a wlast mismatch only flags an error.
                if (s_axi_wvalid && wready_q) begin
                    mem_we  = !w_err_q;
                    w_err_d = w_err_next;
                    if (w_last_beat) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = resp_of(w_err_next);
                        w_state_d = W_RESP;
                    end else begin
                        w_idx_d = w_idx_q + IW'(1);
                        w_cnt_d = w_cnt_q + 8'd1;
                    end
                end
            end
            W_RESP: begin
                if (bvalid_q && s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rid_d     = rid_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        r_idx_d   = r_idx_q;
        r_cnt_d   = r_cnt_q;
        r_len_d   = r_len_q;
        r_err_d   = r_err_q;
        ar_err    = (s_axi_arburst != BURST_INCR);
        mem_re    = 1'b0;
        mem_raddr = r_idx_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (s_axi_arvalid && arready_q) begin
                    rid_d     = s_axi_arid;
                    r_idx_d   = s_axi_araddr[OFF +: IW];
                    r_len_d   = s_axi_arlen;
                    r_cnt_d   = 8'd0;
                    r_err_d   = ar_err;
                    rresp_d   = resp_of(ar_err);
                    rlast_d   = (s_axi_arlen == 8'd0);
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    mem_re    = 1'b1;
                    mem_raddr = s_axi_araddr[OFF +: IW];
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                // Each accepted beat prefetches the next word so rready held high streams one beat per cycle.
                if (rvalid_q && s_axi_rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d   = r_idx_q + IW'(1);
                        r_cnt_d   = r_cnt_q + 8'd1;
                        rlast_d   = ((r_cnt_q + 8'd1) == r_len_q);
                        mem_re    = 1'b1;
                        mem_raddr = r_idx_q + IW'(1);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            w_idx_q   <= '0;
            w_cnt_q   <= 8'd0;
            w_len_q   <= 8'd0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RESP_OKAY;
            rlast_q   <= 1'b0;
            r_idx_q   <= '0;
            r_cnt_q   <= 8'd0;
            r_len_q   <= 8'd0;
            r_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            w_len_q   <= w_len_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rid_q     <= rid_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            r_len_q   <= r_len_d;
            r_err_q   <= r_err_d;
        end
    end

    axi4_slave_ram_mem #(
        .DW    (DW),
        .DEPTH (MEM_DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we),
        .waddr (w_idx_q),
        .wstrb (s_axi_wstrb),
        .wdata (s_axi_wdata),
        .re    (mem_re),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bid     = bid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rid     = rid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rdata   = r_err_q ? '0 : mem_rdata;

endmodule

// File: tb/tb_axi4_slave_ram.sv
// Randomized self-checking bench for axi4_slave_ram against a word-array memory model.
module tb_axi4_slave_ram;

    localparam int DW    = 128;
    localparam int AW    = 28;
    localparam int IDW   = 4;
    localparam int DEPTH = 1024;
    localparam int SW    = DW/8;

    logic            clk = 1'b0;
    logic            reset;
    logic [IDW-1:0]  s_axi_awid;
    logic [AW-1:0]   s_axi_awaddr;
    logic [7:0]      s_axi_awlen;
    logic [2:0]      s_axi_awsize;
    logic [1:0]      s_axi_awburst;
    logic            s_axi_awvalid;
    logic            s_axi_awready;
    logic [DW-1:0]   s_axi_wdata;
    logic [SW-1:0]   s_axi_wstrb;
    logic            s_axi_wlast;
    logic            s_axi_wvalid;
    logic            s_axi_wready;
    logic [IDW-1:0]  s_axi_bid;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready;
    logic [IDW-1:0]  s_axi_arid;
    logic [AW-1:0]   s_axi_araddr;
    logic [7:0]      s_axi_arlen;
    logic [2:0]      s_axi_arsize;
    logic [1:0]      s_axi_arburst;
    logic            s_axi_arvalid;
    logic            s_axi_arready;
    logic [IDW-1:0]  s_axi_rid;
    logic [DW-1:0]   s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rlast;
    logic            s_axi_rvalid;
    logic            s_axi_rready;

    logic [DW-1:0]   model [DEPTH];
    logic [DW-1:0]   wbeat [256];
    logic [SW-1:0]   wstrb_beat [256];
    int              check_count = 0;
    int              pass_count  = 0;

    always #5 clk = ~clk;

    axi4_slave_ram dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    task automatic check_output(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Byte address with random don't-care bits above the word index and below the word boundary.
    function automatic logic [AW-1:0] make_addr(input int word);
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 16383)) << 14;
        a = a | (AW'(word) << 4) | AW'($urandom_range(0, 15));
        return a;
    endfunction

    task automatic write_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                               input logic [1:0] burst, input int wlast_at);
        int t;
        int base;
        logic exp_err;
        base    = int'(addr >> 4) % DEPTH;
        exp_err = (burst != 2'b01) || (wlast_at != int'(len));
        s_axi_awid    = id;
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        s_axi_awsize  = 3'd4;
        s_axi_awburst = burst;
        s_axi_awvalid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < 100) begin @(negedge clk); t++; end
        if (!s_axi_awready) check_output("aw_timeout", DW'(0), DW'(1));
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            s_axi_wdata  = wbeat[b];
            s_axi_wstrb  = wstrb_beat[b];
            s_axi_wlast  = (b == wlast_at);
            s_axi_wvalid = 1'b1;
            t = 0;
            while (!s_axi_wready && t < 100) begin @(negedge clk); t++; end
            if (!s_axi_wready) check_output("w_timeout", DW'(0), DW'(1));
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        check_output("bvalid_latency", DW'(s_axi_bvalid), DW'(1));
        check_output("bid", DW'(s_axi_bid), DW'(id));
        check_output("bresp", DW'(s_axi_bresp), exp_err ? DW'(2) : DW'(0));
        repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check_output("bvalid_hold", DW'(s_axi_bvalid), DW'(1));
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check_output("bvalid_drop", DW'(s_axi_bvalid), DW'(0));
        check_output("awready_after_b", DW'(s_axi_awready), DW'(1));
        if (!exp_err) begin
            for (int b = 0; b <= int'(len); b++)
                for (int j = 0; j < SW; j++)
                    if (wstrb_beat[b][j]) model[(base + b) % DEPTH][j*8 +: 8] = wbeat[b][j*8 +: 8];
        end
    endtask

    task automatic read_burst(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                              input logic [1:0] burst, input int mode);
        int t;
        int k;
        int beat;
        int base;
        logic exp_err;
        logic rdy;
        logic [5:0] pat;
        pat     = 6'b101001;
        base    = int'(addr >> 4) % DEPTH;
        exp_err = (burst != 2'b01);
        s_axi_arid    = id;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = 3'd4;
        s_axi_arburst = burst;
        s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < 100) begin @(negedge clk); t++; end
        if (!s_axi_arready) check_output("ar_timeout", DW'(0), DW'(1));
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        check_output("rvalid_latency", DW'(s_axi_rvalid), DW'(1));
        beat = 0;
        k    = 0;
        t    = 0;
        while (beat <= int'(len) && t < 400) begin
            check_output("rvalid_hold", DW'(s_axi_rvalid), DW'(1));
            check_output("rdata", s_axi_rdata, exp_err ? DW'(0) : model[(base + beat) % DEPTH]);
            check_output("rid", DW'(s_axi_rid), DW'(id));
            check_output("rresp", DW'(s_axi_rresp), exp_err ? DW'(2) : DW'(0));
            check_output("rlast", DW'(s_axi_rlast), DW'(beat == int'(len)));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[k % 6];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            s_axi_rready = rdy;
            k++;
            @(negedge clk);
            if (rdy && s_axi_rvalid !== 1'bx) beat++;
            t++;
        end
        s_axi_rready = 1'b0;
        if (beat <= int'(len)) check_output("r_timeout", DW'(0), DW'(1));
        check_output("rvalid_end", DW'(s_axi_rvalid), DW'(0));
        check_output("arready_end", DW'(s_axi_arready), DW'(1));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset         = 1'b0;
        s_axi_awid    = '0;
        s_axi_awaddr  = '0;
        s_axi_awlen   = '0;
        s_axi_awsize  = '0;
        s_axi_awburst = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wlast   = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_arid    = '0;
        s_axi_araddr  = '0;
        s_axi_arlen   = '0;
        s_axi_arsize  = '0;
        s_axi_arburst = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 'x;

        repeat (3) @(negedge clk);
        check_output("reset_awready", DW'(s_axi_awready), DW'(0));
        check_output("reset_arready", DW'(s_axi_arready), DW'(0));
        check_output("reset_rvalid", DW'(s_axi_rvalid), DW'(0));
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_output("idle_awready", DW'(s_axi_awready), DW'(1));
        check_output("idle_arready", DW'(s_axi_arready), DW'(1));
        check_output("idle_bvalid", DW'(s_axi_bvalid), DW'(0));
        check_output("idle_rvalid", DW'(s_axi_rvalid), DW'(0));
        check_output("idle_wready", DW'(s_axi_wready), DW'(0));
        check_output("idle_rdata", s_axi_rdata, DW'(0));

        // Fill words 0..63 so every later read in that region has a known expected value.
        for (int b = 0; b < 64; b++) begin wbeat[b] = rand_word(); wstrb_beat[b] = '1; end
        write_burst(4'd1, make_addr(0), 8'd63, 2'b01, 63);

        for (int b = 0; b < 4; b++) begin wbeat[b] = DW'(b + 1); wstrb_beat[b] = '1; end
        write_burst(4'd5, 28'h000, 8'd3, 2'b01, 3);
        read_burst(4'd7, 28'h000, 8'd3, 2'b01, 0);

        wbeat[0] = '1; wstrb_beat[0] = '1;
        write_burst(4'd2, make_addr(2), 8'd0, 2'b01, 0);
        wbeat[0] = DW'(8'hAA); wstrb_beat[0] = SW'(1);
        write_burst(4'd2, make_addr(2), 8'd0, 2'b01, 0);
        read_burst(4'd3, make_addr(2), 8'd0, 2'b01, 0);

        read_burst(4'd9, make_addr(8), 8'd7, 2'b01, 1);

        for (int b = 0; b < 4; b++) begin wbeat[b] = rand_word(); wstrb_beat[b] = '1; end
        write_burst(4'd4, make_addr(500), 8'd3, 2'b01, 1);
        write_burst(4'd6, make_addr(10), 8'd3, 2'b00, 3);
        read_burst(4'd6, make_addr(10), 8'd3, 2'b01, 0);
        read_burst(4'd8, make_addr(12), 8'd2, 2'b11, 2);

        wbeat[0] = rand_word(); wbeat[1] = rand_word();
        wstrb_beat[0] = '1; wstrb_beat[1] = '1;
        write_burst(4'd10, make_addr(1023), 8'd1, 2'b01, 1);
        read_burst(4'd11, make_addr(1023), 8'd1, 2'b01, 0);

        for (int b = 0; b < 4; b++) begin wbeat[b] = rand_word(); wstrb_beat[b] = SW'($urandom); end
        fork
            write_burst(4'd12, make_addr(40), 8'd3, 2'b01, 3);
            read_burst(4'd13, make_addr(20), 8'd7, 2'b01, 2);
        join
        read_burst(4'd14, make_addr(40), 8'd3, 2'b01, 0);

        for (int it = 0; it < 40; it++) begin
            int word;
            logic [7:0] len;
            logic [1:0] burst;
            word  = $urandom_range(0, 56);
            len   = 8'($urandom_range(0, 7));
            burst = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b01;
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b < 8; b++) begin wbeat[b] = rand_word(); wstrb_beat[b] = SW'($urandom); end
                write_burst(IDW'($urandom), make_addr(word), len, burst, int'(len));
            end else begin
                read_burst(IDW'($urandom), make_addr(word), len, burst, $urandom_range(0, 2));
            end
        end

        // Abort a read burst with reset after a couple of beats.
        s_axi_arid    = 4'd15;
        s_axi_araddr  = make_addr(30);
        s_axi_arlen   = 8'd7;
        s_axi_arburst = 2'b01;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("midreset_rvalid", DW'(s_axi_rvalid), DW'(0));
        check_output("midreset_rlast", DW'(s_axi_rlast), DW'(0));
        check_output("midreset_arready", DW'(s_axi_arready), DW'(0));
        s_axi_rready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_output("postreset_arready", DW'(s_axi_arready), DW'(1));
        check_output("postreset_awready", DW'(s_axi_awready), DW'(1));
        check_output("postreset_rvalid", DW'(s_axi_rvalid), DW'(0));
        read_burst(4'd1, make_addr(30), 8'd7, 2'b01, 2);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
